majority_filter: RTL
====================

MAJORITY_FILTER -- requirements
Module: majority_filter

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating disagreement counter; SHALL be legal for 2 to 16.
REQ-002 Port: clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset; low SHALL force reset state immediately, independent of clk.
REQ-004 Port: clear, input, 1, synchronous clear of group state and counter.
REQ-005 Port: in_val, input, 1, upstream sample valid.
REQ-006 Port: in_rdy, output, 1, block can accept a sample this cycle.
REQ-007 Port: in_bit, input, 1, sample value.
REQ-008 Port: out_val, output, 1, result of a completed 3-sample group is available.
REQ-009 Port: out_rdy, input, 1, downstream accepts the result.
REQ-010 Port: out_bit, output, 1, majority (pair-or-triple) value of the group.
REQ-011 Port: out_err, output, 1, group samples were not unanimous.
REQ-012 Port: err_count, output, CNT_W, saturating count of non-unanimous groups delivered.

Function
REQ-013 An input transfer SHALL occur on a rising edge exactly when in_val and in_rdy are both 1; an output transfer exactly when out_val and out_rdy are both 1.
REQ-014 FSM states: S0 (0 samples held), S1 (1 held), S2 (2 held), HOLD (result ready).
REQ-015 Transitions: S0->S1, S1->S2, S2->HOLD on input transfer; HOLD->S0 on output transfer; otherwise stay.
REQ-016 in_rdy SHALL be 1 in S0/S1/S2 and 0 in HOLD; out_val SHALL be 1 only in HOLD; both SHALL be registered-state decodes with no combinational path from in_val or out_rdy.
REQ-017 Samples SHALL be stored as s0, s1, s2 in arrival order; the third sample is latched on the S2->HOLD edge.
REQ-018 out_bit SHALL equal (s0&s1)|(s1&s2)|(s0&s2); out_err SHALL equal 1 unless s0==s1==s2.
REQ-019 Latency: out_val SHALL rise on the edge accepting the third sample; minimum throughput one group per 4 cycles.
REQ-020 In states other than HOLD, out_bit and out_err SHALL read 0.
REQ-021 err_count SHALL increment by 1 on each output transfer with out_err=1, saturating at 2^CNT_W-1 (no wrap).
REQ-022 Outputs SHALL hold stable in HOLD while out_rdy=0; in_bit/in_val changes SHALL not alter them.
REQ-023 clear=1 SHALL, on the next edge, return FSM to S0, zero s0..s2 and err_count; clear SHALL take priority over a simultaneous input or output transfer (neither transfer counts; err_count does not increment).
REQ-024 in_val while in HOLD SHALL be ignored; the sample is not consumed.

Reset
REQ-025 While reset=0: FSM=S0, s0..s2=0, err_count=0, in_rdy=1, out_val=0, out_bit=0, out_err=0.
REQ-026 Reset asserted mid-group or in HOLD SHALL discard partial/pending results; no output transfer occurs.
REQ-027 After reset deasserts, the first input transfer SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-028 Samples 0,1,1 with out_rdy=1 -> out_val one cycle after third accept, out_bit=1, out_err=1, err_count=1 next cycle.
REQ-029 All 8 three-sample patterns back to back -> out_bit matches majority truth table (011,101,110,111 ->1), out_err=0 only for 000/111, err_count=6.
REQ-030 Group 1,0,0 then out_rdy=0 for 5 cycles with in_val=1 and in_bit toggling -> in_rdy=0, out_bit=0 and out_err=1 stable, released on out_rdy=1.
REQ-031 CNT_W=2, 5 non-unanimous groups -> err_count 1,2,3,3,3.
REQ-032 reset=0 pulsed between clock edges after two samples -> outputs at reset values immediately; next three samples 1,1,1 -> out_bit=1, out_err=0.
REQ-033 clear=1 on the same edge as an output transfer of an erroneous group with err_count=4 -> state S0, err_count=0.

Source files
------------

// File: rtl/majority_filter.sv
// majority_filter
//   Collects samples in groups of three and presents the majority value of
//   each group, plus a flag that is set when the three samples disagree.
//   Also keeps a saturating count of delivered groups that disagreed.
//
// Ports
//   clk       : single clock, rising edge
//   reset     : asynchronous active-low reset
//   clear     : synchronous clear of group state and error counter
//   in_val    : upstream sample valid
//   in_rdy    : block can accept a sample this cycle
//   in_bit    : sample value
//   out_val   : result of a completed 3-sample group is available
//   out_rdy   : downstream accepts the result
//   out_bit   : majority value of the group (0 unless out_val)
//   out_err   : group samples were not unanimous (0 unless out_val)
//   err_count : saturating count of non-unanimous groups delivered
module majority_filter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic             in_bit,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_bit,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] S0   = 2'd0;
    localparam logic [1:0] S1   = 2'd1;
    localparam logic [1:0] S2   = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0] state;
    logic       s0, s1, s2;
    logic       in_xfer, out_xfer;
    logic       maj, unanimous;

    // Handshake flags decode only from registered state.
    assign in_rdy   = (state != HOLD);
    assign out_val  = (state == HOLD);
    assign in_xfer  = in_val & in_rdy;
    assign out_xfer = out_val & out_rdy;

    assign maj       = (s0 & s1) | (s1 & s2) | (s0 & s2);
    assign unanimous = (s0 == s1) && (s1 == s2);

    // Results are masked outside HOLD so stale samples never leak out.
    assign out_bit = out_val & maj;
    assign out_err = out_val & ~unanimous;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            err_count <= '0;
        end else if (clear) begin
            // Clear wins over any transfer in the same cycle.
            state     <= S0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                S0: if (in_xfer) begin
                    s0    <= in_bit;
                    state <= S1;
                end
                S1: if (in_xfer) begin
                    s1    <= in_bit;
                    state <= S2;
                end
                S2: if (in_xfer) begin
                    s2    <= in_bit;
                    state <= HOLD;
                end
                HOLD: if (out_xfer) begin
                    state <= S0;
                    if (!unanimous && (err_count != '1))
                        err_count <= err_count + CNT_W'(1);
                end
                default: state <= S0;
            endcase
        end
    end

endmodule
